mining_dispatcher: RTL and testbench
====================================

# mining_dispatcher

Job-level controller on the host side of the double-SHA256 mining core. Accepts a job (header, midstate, target, nonce range, id) over valid/ready, launches the core, collects every winning nonce into a small result FIFO, and relaunches the core past each hit until the range is exhausted, a watchdog fires, or the host aborts. Ends each job with a one-cycle completion pulse carrying a status code.

## Interface
- RES_DEPTH, 4: result FIFO entries (power of two, ≥2)
- TIMEOUT_CYCLES, 32'd1_000_000: watchdog limit per launch (used only with MINER_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- job_valid / job_ready  in / out  1 / 1  job handshake; transfer when both high
- job_data  in  [63:0][7:0]  block-2 header bytes
- job_state  in  [7:0][31:0]  midstate
- job_target  in  [31:0][7:0]  hash must compare below this
- job_nonce_start, job_nonce_end  in  32 each  inclusive nonce range
- job_id  in  8  tag echoed on results and completion
- abort  in  1  level; terminate current job
- core_in_valid  out  1  one-cycle launch pulse
- core_in_data, core_in_state, core_target  out  match job_* widths  latched job fields
- core_nonce_base  out  32  first nonce of this launch
- core_out_valid  in  1  core hit flag (level; held until next launch)
- core_nonce_found  in  32;  core_result  in  [31:0][7:0]
- res_valid / res_ready  out / in  1 / 1  result stream
- res_nonce  out  32;  res_hash  out  [31:0][7:0];  res_job_id  out  8
- busy  out  1  high from job accept through DONE
- done_pulse  out  1;  done_status  out  2;  done_job_id  out  8

## Operation
- States: IDLE, LAUNCH, BLANK, WAIT, HOLD, DONE.
- IDLE: job_ready=1. On transfer, latch all job fields, cur_nonce=job_nonce_start. Go to LAUNCH; if start > end, go to DONE with EMPTY.
- LAUNCH (1 cycle): core_in_valid=1, core_nonce_base=cur_nonce. Clear watchdog. Go to BLANK.
- BLANK (2 cycles): core_out_valid ignored (stale hit masking). Then go to WAIT.
- WAIT, on core_out_valid, take hit nonce n:
  - cur_nonce ≤ n ≤ end: push {n, core_result, id}. If the FIFO is full, go to HOLD first.
  - After the push: if n == end or n == 32'hFFFF_FFFF, go to DONE with EXHAUSTED. Otherwise cur_nonce=n+1 and go to LAUNCH.
  - n outside [cur_nonce, end]: discard, go to DONE with EXHAUSTED.
- HOLD: wait for a free FIFO slot, push in that cycle, then apply the same post-push decision.
- DONE (1 cycle): done_pulse=1 with status and id. Go to IDLE.
- Status codes: 0 EXHAUSTED, 1 TIMEOUT, 2 ABORTED, 3 EMPTY.
- Priority in any state other than IDLE/DONE: abort > watchdog > hit. An abort goes to DONE with ABORTED and discards the pending hit.
- The core is not stopped on DONE. The next LAUNCH restarts it.
- FIFO push and pop in the same cycle are legal when full: a pop frees a slot for the same-cycle push. The FIFO is not flushed on abort.
- Nonce arithmetic is 32-bit unsigned. n+1 is computed only when n < 32'hFFFF_FFFF, so there is no wrap.

## Timing
- Reset values: job_ready=1 (IDLE), core_in_valid=0, all core_* data outputs=0, res_valid=0, res_* data=0, busy=0, done_pulse=0, done_status=0, done_job_id=0, FIFO empty.
- Reset asserted mid-job returns to IDLE immediately and drops FIFO contents.
- Job accept to core_in_valid: 1 cycle.
- Hit sampled in WAIT to res_valid: 1 cycle if the FIFO was empty.
- Hit to next core_in_valid: 1 cycle (WAIT→LAUNCH).
- res_* come from the registered FIFO head and are held stable while res_valid && !res_ready.
- job_ready=0 in all states except IDLE. The last result is always pushed before its DONE pulse.

## Configuration
- MINER_TIMEOUT_EN defined: a 32-bit watchdog counts cycles in BLANK/WAIT/HOLD and resets on every LAUNCH. Reaching TIMEOUT_CYCLES goes to DONE with TIMEOUT.
- Undefined: no counter, TIMEOUT is never produced, and a job ends only by EXHAUSTED, ABORTED or EMPTY.

## Structure
- mining_pkg: dispatcher state enum, done_status enum, result record struct {nonce, hash, job_id}, byte-array typedefs for header/midstate/target.
- One sub-module, mining_result_fifo: synchronous, RES_DEPTH entries, full/empty flags, registered head.

## Test plan
- Range 100..200, core hits 150 then 210 → one result (150), status EXHAUSTED, exactly 2 launch pulses with bases 100 and 151.
- Range 5..5, core hits 5 → one result, EXHAUSTED, no relaunch.
- start=10, end=9 → done_pulse the cycle after accept, status EMPTY, no core_in_valid.
- res_ready=0, core hits 1,2,3,4,5 (depth 4) → FSM in HOLD after 4 pushes. Raising res_ready drains in order 1..5 with no loss.
- Abort asserted the same cycle as a hit → ABORTED, hit not queued.
- MINER_TIMEOUT_EN with TIMEOUT_CYCLES=50 and no hit → TIMEOUT pulse after 50 cycles in BLANK/WAIT. Range end=32'hFFFF_FFFF with a hit at 32'hFFFF_FFFF → EXHAUSTED, no wrap.

Source files
------------

// File: rtl/mining_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mining_pkg
// Description : Shared types for the mining job dispatcher and its result FIFO.
// Revision    : 1.0
// ============================================================================
package mining_pkg;

    typedef logic [63:0][7:0] header_t;
    typedef logic [7:0][31:0] midstate_t;
    typedef logic [31:0][7:0] target_t;
    typedef logic [31:0][7:0] hash_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BLANK  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } disp_state_e;

    typedef enum logic [1:0] {
        STAT_EXHAUSTED = 2'd0,
        STAT_TIMEOUT   = 2'd1,
        STAT_ABORTED   = 2'd2,
        STAT_EMPTY     = 2'd3
    } done_status_e;

    typedef struct packed {
        logic [31:0] nonce;
        hash_t       hash;
        logic [7:0]  job_id;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/mining_dispatcher_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mining_result_fifo
// Description : Shift-style result FIFO; entry 0 is the registered head.
// Revision    : 1.0
// ============================================================================
module mining_result_fifo
    import mining_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  result_t push_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output result_t head_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    result_t       entry_q [DEPTH];
    logic [CW-1:0] count_q;
    logic          do_pop;
    logic          do_push;
    logic [IW-1:0] wr_pos;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push_i && (!full_o || do_pop);
    assign wr_pos  = IW'(count_q - CW'(do_pop));
    assign head_o  = entry_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    entry_q[i] <= entry_q[i + 1];
                end
                entry_q[DEPTH - 1] <= '0;
            end
            if (do_push) begin
                entry_q[wr_pos] <= push_data_i;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mining_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : mining_dispatcher
// Description : Job controller for the double-SHA256 core; relaunches past
//               each hit, queues winners, signals job completion.
//               Optional watchdog: define MINER_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module mining_dispatcher
    import mining_pkg::*;
#(
    parameter int unsigned RES_DEPTH      = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [63:0][7:0] job_data,
    input  logic [7:0][31:0] job_state,
    input  logic [31:0][7:0] job_target,
    input  logic [31:0]      job_nonce_start,
    input  logic [31:0]      job_nonce_end,
    input  logic [7:0]       job_id,
    input  logic             abort,
    output logic             core_in_valid,
    output logic [63:0][7:0] core_in_data,
    output logic [7:0][31:0] core_in_state,
    output logic [31:0][7:0] core_target,
    output logic [31:0]      core_nonce_base,
    input  logic             core_out_valid,
    input  logic [31:0]      core_nonce_found,
    input  logic [31:0][7:0] core_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_nonce,
    output logic [31:0][7:0] res_hash,
    output logic [7:0]       res_job_id,
    output logic             busy,
    output logic             done_pulse,
    output logic [1:0]       done_status,
    output logic [7:0]       done_job_id
);

    disp_state_e  state_q, state_d;
    done_status_e status_q, status_d;
    logic [31:0]  cur_q, cur_d;
    logic         blank_q, blank_d;
    logic [31:0]  end_q;
    logic [7:0]   id_q;
    header_t      data_q;
    midstate_t    mid_q;
    target_t      target_q;
    logic [31:0]  hold_nonce_q;
    hash_t        hold_hash_q;

    logic         hit_capture;
    logic         fifo_push;
    logic         fifo_full;
    logic         fifo_empty;
    result_t      fifo_head;
    result_t      push_rec;
    logic [31:0]  hit_nonce;
    hash_t        hit_hash;
    logic         hit_in_range;
    logic         hit_last;
    logic         can_push;
    logic         active;
    logic         wd_fire;

`ifdef MINER_TIMEOUT_EN
    logic [31:0] wd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q == ST_LAUNCH) begin
            wd_q <= '0;
        end else if (state_q inside {ST_BLANK, ST_WAIT, ST_HOLD}) begin
            wd_q <= wd_q + 32'd1;
        end
    end

    assign wd_fire = (state_q inside {ST_BLANK, ST_WAIT, ST_HOLD}) &&
                     (wd_q == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_fire        = 1'b0;
`endif

    // In HOLD the hit was captured on entry; elsewhere it comes live from the core.
    assign hit_nonce    = (state_q == ST_HOLD) ? hold_nonce_q : core_nonce_found;
    assign hit_hash     = (state_q == ST_HOLD) ? hold_hash_q  : core_result;
    assign hit_in_range = (hit_nonce >= cur_q) && (hit_nonce <= end_q);
    assign hit_last     = (hit_nonce == end_q) || (hit_nonce == 32'hFFFF_FFFF);
    assign can_push     = !fifo_full || res_ready;
    assign active       = state_q inside {ST_LAUNCH, ST_BLANK, ST_WAIT, ST_HOLD};
    assign push_rec     = '{nonce: hit_nonce, hash: hit_hash, job_id: id_q};

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        cur_d       = cur_q;
        blank_d     = blank_q;
        hit_capture = 1'b0;
        fifo_push   = 1'b0;
        if (active && abort) begin
            state_d  = ST_DONE;
            status_d = STAT_ABORTED;
        end else if (wd_fire) begin
            state_d  = ST_DONE;
            status_d = STAT_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_valid) begin
                        cur_d = job_nonce_start;
                        if (job_nonce_start > job_nonce_end) begin
                            state_d  = ST_DONE;
                            status_d = STAT_EMPTY;
                        end else begin
                            state_d = ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    blank_d = 1'b0;
                    state_d = ST_BLANK;
                end
                ST_BLANK: begin
                    blank_d = 1'b1;
                    if (blank_q) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT, ST_HOLD: begin
                    if (state_q == ST_WAIT && core_out_valid && !hit_in_range) begin
                        state_d  = ST_DONE;
                        status_d = STAT_EXHAUSTED;
                    end else if (state_q == ST_HOLD || core_out_valid) begin
                        if (!can_push) begin
                            hit_capture = (state_q == ST_WAIT);
                            state_d     = ST_HOLD;
                        end else begin
                            fifo_push = 1'b1;
                            if (hit_last) begin
                                state_d  = ST_DONE;
                                status_d = STAT_EXHAUSTED;
                            end else begin
                                cur_d   = hit_nonce + 32'd1;
                                state_d = ST_LAUNCH;
                            end
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            status_q <= STAT_EXHAUSTED;
            cur_q    <= '0;
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cur_q    <= cur_d;
            blank_q  <= blank_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            mid_q        <= '0;
            target_q     <= '0;
            end_q        <= '0;
            id_q         <= '0;
            hold_nonce_q <= '0;
            hold_hash_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && job_valid) begin
                data_q   <= job_data;
                mid_q    <= job_state;
                target_q <= job_target;
                end_q    <= job_nonce_end;
                id_q     <= job_id;
            end
            if (hit_capture) begin
                hold_nonce_q <= core_nonce_found;
                hold_hash_q  <= core_result;
            end
        end
    end

    mining_result_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_rec),
        .pop_i       (res_ready),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign job_ready       = (state_q == ST_IDLE);
    assign core_in_valid   = (state_q == ST_LAUNCH);
    assign core_in_data    = data_q;
    assign core_in_state   = mid_q;
    assign core_target     = target_q;
    assign core_nonce_base = cur_q;
    assign res_valid       = !fifo_empty;
    assign res_nonce       = fifo_head.nonce;
    assign res_hash        = fifo_head.hash;
    assign res_job_id      = fifo_head.job_id;
    assign busy            = (state_q != ST_IDLE);
    assign done_pulse      = (state_q == ST_DONE);
    assign done_status     = status_q;
    assign done_job_id     = id_q;

endmodule
`default_nettype wire

// File: tb/tb_mining_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_mining_dispatcher
// Description : Directed self-checking bench for mining_dispatcher.
// Revision    : 1.0
// ============================================================================
module tb_mining_dispatcher;

    logic             clk;
    logic             rst_n;
    logic             job_valid;
    logic             job_ready;
    logic [63:0][7:0] job_data;
    logic [7:0][31:0] job_state;
    logic [31:0][7:0] job_target;
    logic [31:0]      job_nonce_start;
    logic [31:0]      job_nonce_end;
    logic [7:0]       job_id;
    logic             abort;
    logic             core_in_valid;
    logic [63:0][7:0] core_in_data;
    logic [7:0][31:0] core_in_state;
    logic [31:0][7:0] core_target;
    logic [31:0]      core_nonce_base;
    logic             core_out_valid;
    logic [31:0]      core_nonce_found;
    logic [31:0][7:0] core_result;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_nonce;
    logic [31:0][7:0] res_hash;
    logic [7:0]       res_job_id;
    logic             busy;
    logic             done_pulse;
    logic [1:0]       done_status;
    logic [7:0]       done_job_id;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          launches = 0;
    int          done_cnt = 0;
    logic [31:0] bases[$];
    logic [31:0] res_q[$];

    mining_dispatcher #(
        .RES_DEPTH      (4),
        .TIMEOUT_CYCLES (32'd50)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_data         (job_data),
        .job_state        (job_state),
        .job_target       (job_target),
        .job_nonce_start  (job_nonce_start),
        .job_nonce_end    (job_nonce_end),
        .job_id           (job_id),
        .abort            (abort),
        .core_in_valid    (core_in_valid),
        .core_in_data     (core_in_data),
        .core_in_state    (core_in_state),
        .core_target      (core_target),
        .core_nonce_base  (core_nonce_base),
        .core_out_valid   (core_out_valid),
        .core_nonce_found (core_nonce_found),
        .core_result      (core_result),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_nonce        (res_nonce),
        .res_hash         (res_hash),
        .res_job_id       (res_job_id),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .done_status      (done_status),
        .done_job_id      (done_job_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && core_in_valid) begin
            launches++;
            bases.push_back(core_nonce_base);
        end
        if (rst_n && res_valid && res_ready) res_q.push_back(res_nonce);
        if (rst_n && done_pulse) done_cnt++;
    end

    function automatic logic [255:0] hash_for(input logic [31:0] n);
        return {8{n ^ 32'hDEAD_BEEF}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(input logic [31:0] n);
        core_out_valid   = 1'b1;
        core_nonce_found = n;
        core_result      = hash_for(n);
    endtask

    task automatic send_job(input logic [31:0] s, input logic [31:0] e, input logic [7:0] id);
        job_nonce_start = s;
        job_nonce_end   = e;
        job_id          = id;
        job_valid       = 1'b1;
        step();
        job_valid       = 1'b0;
    endtask

    task automatic wait_launch(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (core_in_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output logic seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            cycles++;
            if (done_pulse) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic seen;
        int   cyc;
        int   l0;
        int   d0;

        rst_n            = 1'b0;
        job_valid        = 1'b0;
        job_data         = {16{32'h0123_4567}};
        job_state        = {8{32'h6A09_E667}};
        job_target       = {8{32'h0000_FFFF}};
        job_nonce_start  = '0;
        job_nonce_end    = '0;
        job_id           = '0;
        abort            = 1'b0;
        core_out_valid   = 1'b0;
        core_nonce_found = '0;
        core_result      = '0;
        res_ready        = 1'b1;

        // Reset values
        repeat (3) step();
        chk("rst_job_ready", job_ready, 1);
        chk("rst_core_in_valid", core_in_valid, 0);
        chk("rst_core_nonce_base", core_nonce_base, 0);
        chk("rst_core_target", core_target, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_nonce", res_nonce, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done_pulse, done_status, done_job_id}, 0);
        rst_n = 1'b1;
        step();

        // Range 100..200: stale hit masked, hit 150 queued, hit 210 ends the job
        l0 = launches;
        send_job(32'd100, 32'd200, 8'h11);
        chk("t1_launch_latency", core_in_valid, 1);
        chk("t1_base0", core_nonce_base, 100);
        chk("t1_busy", {busy, job_ready}, 2'b10);
        chk("t1_target_latched", core_target, {8{32'h0000_FFFF}});
        set_hit(32'd7);
        repeat (3) step();
        chk("t1_stale_masked", {done_pulse, core_in_valid}, 0);
        set_hit(32'd150);
        step();
        chk("t1_relaunch", core_in_valid, 1);
        chk("t1_base1", core_nonce_base, 151);
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_nonce", res_nonce, 150);
        chk("t1_res_hash", res_hash, hash_for(32'd150));
        chk("t1_res_id", res_job_id, 8'h11);
        set_hit(32'd210);
        wait_done(30, seen, cyc);
        chk("t1_done_seen", seen, 1);
        chk("t1_done_status", done_status, 0);
        chk("t1_done_id", done_job_id, 8'h11);
        chk("t1_launches", launches - l0, 2);
        chk("t1_bases", {bases[l0], bases[l0 + 1]}, {32'd100, 32'd151});
        chk("t1_results", {res_q.size(), res_q[0]}, {32'd1, 32'd150});
        core_out_valid = 1'b0;
        step();

        // Range 5..5 with hit 5: one result, no relaunch
        l0 = launches;
        send_job(32'd5, 32'd5, 8'h22);
        set_hit(32'd5);
        wait_done(30, seen, cyc);
        chk("t2_done_seen", seen, 1);
        chk("t2_done", {done_status, done_job_id}, {2'd0, 8'h22});
        step();
        chk("t2_launches", launches - l0, 1);
        chk("t2_results", {res_q.size(), res_q[1]}, {32'd2, 32'd5});
        core_out_valid = 1'b0;

        // start > end: immediate EMPTY, no launch
        l0 = launches;
        send_job(32'd10, 32'd9, 8'h33);
        chk("t3_done_pulse", done_pulse, 1);
        chk("t3_done", {done_status, done_job_id}, {2'd3, 8'h33});
        chk("t3_no_launch", core_in_valid, 0);
        step();
        chk("t3_idle", {job_ready, launches - l0}, {1'b1, 32'd0});

        // Backpressure: hits 1..5 into a depth-4 FIFO, then drain
        res_q.delete();
        res_ready = 1'b0;
        l0 = launches;
        send_job(32'd0, 32'd100, 8'h44);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                wait_launch(20, seen);
                chk("t4_launch_seen", seen, 1);
            end
            chk("t4_base", core_nonce_base, (k == 1) ? 0 : k);
            set_hit(k);
        end
        d0 = done_cnt;
        repeat (8) step();
        chk("t4_hold_no_relaunch", launches - l0, 5);
        chk("t4_hold_no_done", done_cnt - d0, 0);
        chk("t4_hold_head", {res_valid, res_nonce}, {1'b1, 32'd1});
        chk("t4_hold_busy", busy, 1);
        res_ready = 1'b1;
        wait_launch(20, seen);
        chk("t4_resume_seen", seen, 1);
        chk("t4_resume_base", core_nonce_base, 6);

        // Abort in the same cycle as a hit: ABORTED and the hit is dropped
        core_out_valid = 1'b0;
        repeat (3) step();
        set_hit(32'd7);
        abort = 1'b1;
        step();
        chk("t5_done_pulse", done_pulse, 1);
        chk("t5_done", {done_status, done_job_id}, {2'd2, 8'h44});
        abort          = 1'b0;
        core_out_valid = 1'b0;
        repeat (3) step();
        chk("t4_drain_count", res_q.size(), 5);
        for (int i = 0; i < 5 && i < res_q.size(); i++) begin
            chk("t4_drain_order", res_q[i], i + 1);
        end
        chk("t5_fifo_empty", res_valid, 0);

        // Hit at the top of the nonce space: EXHAUSTED without wrap
        l0 = launches;
        send_job(32'hFFFF_FFF0, 32'hFFFF_FFFF, 8'h66);
        set_hit(32'hFFFF_FFFF);
        wait_done(30, seen, cyc);
        chk("t6_done_seen", seen, 1);
        chk("t6_done", {done_status, done_job_id}, {2'd0, 8'h66});
        step();
        chk("t6_launches", launches - l0, 1);
        chk("t6_result", res_q[res_q.size() - 1], 32'hFFFF_FFFF);
        core_out_valid = 1'b0;

        // Reset mid-job drops state and FIFO contents
        res_ready = 1'b0;
        send_job(32'd0, 32'd50, 8'h77);
        set_hit(32'd3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t7_res_before_reset", seen, 1);
        core_out_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_reset", {job_ready, busy, res_valid, core_in_valid}, 4'b1000);
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        step();

`ifdef MINER_TIMEOUT_EN
        send_job(32'd0, 32'd10, 8'h88);
        wait_done(200, seen, cyc);
        chk("t8_timeout_seen", seen, 1);
        chk("t8_timeout_cycles", cyc, 51);
        chk("t8_timeout", {done_status, done_job_id}, {2'd1, 8'h88});
`else
        d0 = done_cnt;
        send_job(32'd0, 32'd10, 8'h88);
        repeat (100) step();
        chk("t8_no_timeout", {done_cnt - d0, busy}, {32'd0, 1'b1});
        abort = 1'b1;
        step();
        chk("t8_abort", {done_pulse, done_status, done_job_id}, {1'b1, 2'd2, 8'h88});
        abort = 1'b0;
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
